// File: rtl/vmem_responder_if.sv
// Bundles the vector-side request/return signals and the shared data-memory port of vmem_responder.
// The responder uses the slave view; whatever drives the requests and models memory uses the master view.
interface vmem_responder_if #(
    parameter int AW = 32
);
    logic          i_write_en;
    logic [31:0]   i_write_data;
    logic          i_read_en;
    logic [AW-1:0] i_memaddr;
    logic          o_read_vd;
    logic [31:0]   o_read_data;
    logic          o_busy;
    logic          o_err;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          i_mem_gnt;
    logic          i_mem_rvalid;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_write_en, i_write_data, i_read_en, i_memaddr,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_read_vd, o_read_data, o_busy, o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_write_en, i_write_data, i_read_en, i_memaddr,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_read_vd, o_read_data, o_busy, o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/vmem_responder.sv
// Queues vector word loads/stores in order, issues them to a stallable data-memory port and
// returns load data in order; overflow and protocol violations raise a sticky error flag.
module vmem_responder #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    vmem_responder_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    req_t          fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic          read_vd_q, read_vd_d;
    logic [31:0]   read_data_q, read_data_d;

    req_t head;
    logic fifo_empty, fifo_full;
    logic push_req, push_ok, pop, issue_rd, rsp_ok, mem_req;
    logic err_event;

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push_req   = bus.i_write_en | bus.i_read_en;

    // A read at the head waits while every return slot is already in flight; writes never wait.
    assign mem_req  = !fifo_empty && !(!head.we && (outst_q == DEPTH_C));
    assign pop      = mem_req & bus.i_mem_gnt;
    assign push_ok  = push_req & (!fifo_full | pop);
    assign issue_rd = pop & !head.we;
    assign rsp_ok   = bus.i_mem_rvalid & (outst_q != '0);

    assign err_event = (bus.i_write_en & bus.i_read_en)
                     | (push_req & fifo_full & !pop)
                     | (push_req & (bus.i_memaddr[1:0] != 2'b00))
                     | (bus.i_mem_rvalid & (outst_q == '0));

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= '{we:    bus.i_write_en,
                                    addr:  {bus.i_memaddr[AW-1:2], 2'b00},
                                    wdata: bus.i_write_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({issue_rd, rsp_ok})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        err_d       = err_q | err_event;
        read_vd_d   = rsp_ok;
        read_data_d = rsp_ok ? bus.i_mem_rdata : read_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            state_q     <= IDLE;
            err_q       <= 1'b0;
            read_vd_q   <= 1'b0;
            read_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            state_q     <= state_d;
            err_q       <= err_d;
            read_vd_q   <= read_vd_d;
            read_data_q <= read_data_d;
        end
    end

    // Decisions use post-update occupancy so a pop and an enqueue in the same cycle keep ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push_ok) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (count_d == '0) state_d = (outst_d != '0) ? WAIT : IDLE;
            end
            WAIT: begin
                if (push_ok)             state_d = ACTIVE;
                else if (outst_d == '0)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy      = (state_q != IDLE);
        bus.o_mem_req   = mem_req;
        bus.o_mem_we    = mem_req & head.we;
        bus.o_mem_addr  = mem_req ? head.addr : '0;
        bus.o_mem_wdata = mem_req ? head.wdata : '0;
        bus.o_read_vd   = read_vd_q;
        bus.o_read_data = read_data_q;
        bus.o_err       = err_q;
    end
endmodule

// File: tb/tb_vmem_responder.sv
// Directed bench for vmem_responder: a scoreboard of expected memory operations and load returns,
// plus a memory model returning rdata = address two cycles after each granted read.
module tb_vmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vmem_responder_if #(.AW(32)) vif ();

    vmem_responder #(.DEPTH(4), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mop_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    mop_t        exp_mem [$];
    logic [31:0] exp_rd  [$];
    pend_t       rd_pend [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_wr  = 0;
    int n_vd  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any grant, advance, score any load return, then drive the memory return.
    task automatic tick();
        mop_t m;
        if (vif.o_mem_req && vif.i_mem_gnt) begin
            if (vif.o_mem_we) n_wr++;
            chk("mem_op_expected", 32'(exp_mem.size() != 0), 32'd1);
            if (exp_mem.size() != 0) begin
                m = exp_mem.pop_front();
                chk("mem_we", 32'(vif.o_mem_we), 32'(m.we));
                chk("mem_addr", vif.o_mem_addr, m.addr);
                if (m.we) chk("mem_wdata", vif.o_mem_wdata, m.wdata);
            end
            $display("[%0d] mem grant we=%0d addr=0x%0h wdata=0x%0h", cyc, vif.o_mem_we, vif.o_mem_addr, vif.o_mem_wdata);
            if (!vif.o_mem_we) rd_pend.push_back('{due: cyc + 2, data: vif.o_mem_addr});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (vif.o_read_vd) begin
            n_vd++;
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) chk("rd_data", vif.o_read_data, exp_rd.pop_front());
            $display("[%0d] load return data=0x%0h", cyc, vif.o_read_data);
        end
        vif.i_mem_rvalid = 1'b0;
        if (rd_pend.size() != 0 && rd_pend[0].due <= cyc) begin
            vif.i_mem_rvalid = 1'b1;
            vif.i_mem_rdata  = rd_pend[0].data;
            void'(rd_pend.pop_front());
        end
    endtask

    task automatic send(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] data, input bit acc);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        vif.i_write_en   = we;
        vif.i_read_en    = re;
        vif.i_memaddr    = addr;
        vif.i_write_data = data;
        if (acc) begin
            exp_mem.push_back('{we: we, addr: waddr, wdata: data});
            if (!we) exp_rd.push_back(waddr);
        end
        $display("[%0d] request we=%0d re=%0d addr=0x%0h data=0x%0h accept=%0d", cyc, we, re, addr, data, acc);
        tick();
        vif.i_write_en = 1'b0;
        vif.i_read_en  = 1'b0;
    endtask

    task automatic do_reset(input bit keep_pend);
        rst = 1'b0;
        #2;
        chk("rst_read_vd",   32'(vif.o_read_vd), 32'd0);
        chk("rst_read_data", vif.o_read_data, 32'd0);
        chk("rst_busy",      32'(vif.o_busy), 32'd0);
        chk("rst_err",       32'(vif.o_err), 32'd0);
        chk("rst_mem_req",   32'(vif.o_mem_req), 32'd0);
        chk("rst_mem_we",    32'(vif.o_mem_we), 32'd0);
        chk("rst_mem_addr",  vif.o_mem_addr, 32'd0);
        chk("rst_mem_wdata", vif.o_mem_wdata, 32'd0);
        exp_mem.delete();
        exp_rd.delete();
        if (!keep_pend) begin
            rd_pend.delete();
            vif.i_mem_rvalid = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_mem.size() + exp_rd.size() + rd_pend.size()) != 0; i++)
            tick();
        chk("drain_done", 32'(exp_mem.size() + exp_rd.size() + rd_pend.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        int vd0;
        vif.i_write_en = 0; vif.i_read_en = 0; vif.i_memaddr = 0; vif.i_write_data = 0;
        vif.i_mem_gnt = 0; vif.i_mem_rvalid = 0; vif.i_mem_rdata = 0;

        // 1: reset with random inputs
        vif.i_write_en   = 1'($urandom);
        vif.i_read_en    = 1'($urandom);
        vif.i_memaddr    = $urandom;
        vif.i_write_data = $urandom;
        vif.i_mem_gnt    = 1'($urandom);
        vif.i_mem_rvalid = 1'($urandom);
        vif.i_mem_rdata  = $urandom;
        repeat (3) @(posedge clk);
        do_reset(0);
        vif.i_write_en = 0; vif.i_read_en = 0; vif.i_mem_gnt = 0; vif.i_mem_rvalid = 0;
        tick();
        chk("t1_busy", 32'(vif.o_busy), 32'd0);
        chk("t1_mem_req", 32'(vif.o_mem_req), 32'd0);

        // 2: single store
        vif.i_mem_gnt = 1'b1;
        send(1, 0, 32'h100, 32'hDEADBEEF, 1);
        chk("t2_mem_req", 32'(vif.o_mem_req), 32'd1);
        chk("t2_mem_we", 32'(vif.o_mem_we), 32'd1);
        chk("t2_mem_addr", vif.o_mem_addr, 32'h100);
        chk("t2_mem_wdata", vif.o_mem_wdata, 32'hDEADBEEF);
        chk("t2_busy_on", 32'(vif.o_busy), 32'd1);
        tick();
        chk("t2_req_off", 32'(vif.o_mem_req), 32'd0);
        chk("t2_busy_off", 32'(vif.o_busy), 32'd0);
        chk("t2_err", 32'(vif.o_err), 32'd0);

        // 3: load burst
        vd0 = n_vd;
        for (int i = 0; i < 4; i++) send(0, 1, 32'h200 + 32'(4 * i), 32'h0, 1);
        drain(30);
        chk("t3_returns", 32'(n_vd - vd0), 32'd4);
        chk("t3_busy", 32'(vif.o_busy), 32'd0);
        chk("t3_err", 32'(vif.o_err), 32'd0);

        // 4: overflow with memory stalled
        vif.i_mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) send(1, 0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), i < 4);
        chk("t4_err", 32'(vif.o_err), 32'd1);
        chk("t4_req_held", 32'(vif.o_mem_req), 32'd1);
        chk("t4_addr_held", vif.o_mem_addr, 32'h300);
        wr0 = n_wr;
        vif.i_mem_gnt = 1'b1;
        drain(20);
        repeat (3) tick();
        chk("t4_writes", 32'(n_wr - wr0), 32'd4);
        chk("t4_req_off", 32'(vif.o_mem_req), 32'd0);

        // 5: full FIFO with a simultaneous pop
        do_reset(0);
        vif.i_mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 0, 32'h400 + 32'(4 * i), 32'h2000 + 32'(i), 1);
        wr0 = n_wr;
        vif.i_mem_gnt = 1'b1;
        send(1, 0, 32'h410, 32'h2004, 1);
        drain(20);
        chk("t5_writes", 32'(n_wr - wr0), 32'd5);
        chk("t5_err", 32'(vif.o_err), 32'd0);

        // 6a: misaligned read
        do_reset(0);
        vif.i_mem_gnt = 1'b1;
        send(0, 1, 32'h102, 32'h0, 1);
        chk("t6a_mem_req", 32'(vif.o_mem_req), 32'd1);
        chk("t6a_mem_addr", vif.o_mem_addr, 32'h100);
        chk("t6a_err", 32'(vif.o_err), 32'd1);
        drain(20);

        // 6b: spurious return with nothing outstanding
        do_reset(0);
        vif.i_mem_rvalid = 1'b1;
        vif.i_mem_rdata  = 32'hAAAA5555;
        tick();
        chk("t6b_read_vd", 32'(vif.o_read_vd), 32'd0);
        chk("t6b_err", 32'(vif.o_err), 32'd1);

        // 6c: reset in the middle of a load burst
        do_reset(0);
        vif.i_mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 1, 32'h500 + 32'(4 * i), 32'h0, 1);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6c_no_read_vd", 32'(vif.o_read_vd), 32'd0);
        end
        chk("t6c_busy", 32'(vif.o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
